// File: rtl/fetch_buf.sv
// fetch_buf: rv32i instruction-fetch unit.
// Owns the program counter, issues word fetches over a req/gnt/rvalid
// instruction-memory port, and queues returned instructions (with their PCs)
// in a DEPTH-entry in-order buffer that feeds decode via valid/ready.
// A redirect flushes the buffer and discards every in-flight response.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned-redirect flag + halt).
module fetch_buf #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        fet_pc_update_i,
   input  logic [31:0] fet_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        ins_valid_o,
   output logic [31:0] ins_pc_o,
   output logic [31:0] ins_data_o,
   input  logic        ins_ready_i,
   output logic        fet_misalign_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   // Drop counter carries extra headroom: back-to-back redirects can stack
   // more unanswered fetches than the queue itself holds.
   localparam int unsigned DW = PW + 3;

   logic [31:0]       req_pc_q, req_pc_d;
   logic              start_q;
   logic [31:0]       pc_q   [DEPTH];
   logic [31:0]       data_q [DEPTH];
   logic [DEPTH-1:0]  filled_q, filled_d;
   logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d;
   logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
   logic [PW-1:0]     head_ptr_q, head_ptr_d;
   logic [CW-1:0]     alloc_cnt_q, alloc_cnt_d;
   logic [CW-1:0]     pend_cnt_q, pend_cnt_d;   // allocated, awaiting data
   logic [DW-1:0]     drop_cnt_q, drop_cnt_d;   // stale responses to discard

   logic              halted_s;
   logic [31:0]       tgt_s;
   logic              grant_s;
   logic              pop_s;
   logic              drop_rsp_s;
   logic              keep_rsp_s;
   logic              rsp_any_s;

`ifdef FETCH_MISALIGN_CHK_EN
   logic halted_q, halted_d;
   logic misalign_q, misalign_d;

   assign tgt_s          = fet_pc_i;
   assign halted_s       = halted_q;
   assign fet_misalign_o = misalign_q;

   // Misaligned redirect: one-cycle flag and halt until an aligned redirect.
   always_comb begin
      halted_d   = halted_q;
      misalign_d = 1'b0;
      if (fet_pc_update_i) begin
         halted_d   = (fet_pc_i[1:0] != 2'b00);
         misalign_d = (fet_pc_i[1:0] != 2'b00);
      end else begin
         halted_d   = halted_q;
      end
   end

   // Halt / misalign flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         halted_q   <= halted_d;
         misalign_q <= misalign_d;
      end
   end
`else
   // Low address bits of a redirect target are simply ignored.
   assign tgt_s          = fet_pc_i & 32'hFFFF_FFFC;
   assign halted_s       = 1'b0;
   assign fet_misalign_o = 1'b0;
`endif

   assign imem_req_o  = start_q & en_i & ~fet_pc_update_i & ~halted_s &
                        (alloc_cnt_q < CW'(DEPTH));
   assign imem_addr_o = req_pc_q;
   assign ins_valid_o = (alloc_cnt_q != {CW{1'b0}}) & filled_q[head_ptr_q];
   assign ins_pc_o    = pc_q[head_ptr_q];
   assign ins_data_o  = data_q[head_ptr_q];

   assign grant_s    = imem_req_o & imem_gnt_i;
   assign pop_s      = ins_valid_o & ins_ready_i & ~fet_pc_update_i;
   assign drop_rsp_s = imem_rvalid_i & (drop_cnt_q != {DW{1'b0}});
   assign keep_rsp_s = imem_rvalid_i & (drop_cnt_q == {DW{1'b0}}) &
                       (pend_cnt_q != {CW{1'b0}});
   assign rsp_any_s  = drop_rsp_s | keep_rsp_s;

   // Next-state for PC, pointers, counters and fill flags.
   always_comb begin
      req_pc_d    = req_pc_q;
      filled_d    = filled_q;
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      head_ptr_d  = head_ptr_q;
      alloc_cnt_d = alloc_cnt_q;
      pend_cnt_d  = pend_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (fet_pc_update_i) begin
         // Flush: everything still unanswered (less a response landing now)
         // must be discarded when it eventually returns.
         req_pc_d    = tgt_s;
         filled_d    = {DEPTH{1'b0}};
         alloc_ptr_d = {PW{1'b0}};
         fill_ptr_d  = {PW{1'b0}};
         head_ptr_d  = {PW{1'b0}};
         alloc_cnt_d = {CW{1'b0}};
         pend_cnt_d  = {CW{1'b0}};
         drop_cnt_d  = drop_cnt_q + DW'(pend_cnt_q) - DW'(rsp_any_s);
      end else begin
         if (grant_s) begin
            alloc_ptr_d = alloc_ptr_q + PW'(1);
            req_pc_d    = req_pc_q + 32'd4;
         end else begin
            alloc_ptr_d = alloc_ptr_q;
         end
         if (drop_rsp_s) begin
            drop_cnt_d = drop_cnt_q - DW'(1);
         end else if (keep_rsp_s) begin
            filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d           = fill_ptr_q + PW'(1);
         end else begin
            fill_ptr_d = fill_ptr_q;
         end
         if (pop_s) begin
            filled_d[head_ptr_q] = 1'b0;
            head_ptr_d           = head_ptr_q + PW'(1);
         end else begin
            head_ptr_d = head_ptr_q;
         end
         alloc_cnt_d = alloc_cnt_q + CW'(grant_s) - CW'(pop_s);
         pend_cnt_d  = pend_cnt_q + CW'(grant_s) - CW'(keep_rsp_s);
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_pc_q    <= RESET_PC;
         start_q     <= 1'b0;
         filled_q    <= {DEPTH{1'b0}};
         alloc_ptr_q <= {PW{1'b0}};
         fill_ptr_q  <= {PW{1'b0}};
         head_ptr_q  <= {PW{1'b0}};
         alloc_cnt_q <= {CW{1'b0}};
         pend_cnt_q  <= {CW{1'b0}};
         drop_cnt_q  <= {DW{1'b0}};
      end else begin
         req_pc_q    <= req_pc_d;
         start_q     <= 1'b1;
         filled_q    <= filled_d;
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         alloc_cnt_q <= alloc_cnt_d;
         pend_cnt_q  <= pend_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Queue payload storage; contents are qualified by the fill flags.
   always_ff @(posedge clk_i) begin
      if (grant_s) begin
         pc_q[alloc_ptr_q] <= req_pc_q;
      end
      if (keep_rsp_s && !fet_pc_update_i) begin
         data_q[fill_ptr_q] <= imem_rdata_i;
      end
   end

endmodule
